serial_adder_ctrl: RTL and testbench

Bit-serial add/subtract engine. One 1-bit full-adder cell is shared between two requesters. The block arbitrates round-robin between the requesters and latches the winner's operands. It then runs the full-adder cell LSB-first over WIDTH cycles and returns the sum, carry-out and signed overflow with a per-requester done pulse. It sits between lab-level operand sources and the single full-adder slice, as a small area-minimal alternative to a ripple-carry array.

---
 rtl/serial_adder_ctrl.sv | 138 +++++++++++++
 tb/tb_serial_adder_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract engine: one full-adder slice shared round-robin
// between two requesters, operands processed LSB-first over WIDTH cycles.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             sub0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic             sub1,
    output logic             busy,
    output logic             gnt,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic             gnt_q, gnt_d;
    logic             last_q, last_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] rs_q, rs_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic             cmsb_q, cmsb_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             win;
    logic             win_sub;
    logic             fa_sum;
    logic             fa_co;

    // The single shared full-adder slice.
    assign fa_sum = sa_q[0] ^ sb_q[0] ^ carry_q;
    assign fa_co  = (sa_q[0] & sb_q[0]) | (carry_q & (sa_q[0] ^ sb_q[0]));

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        last_d   = last_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        rs_d     = rs_q;
        result_d = result_q;
        carry_d  = carry_q;
        cmsb_d   = cmsb_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        cnt_d    = cnt_q;

        // On a tie the requester that was not served last wins.
        win     = (req0 && req1) ? ~last_q : req1;
        win_sub = win ? sub1 : sub0;

        unique case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    gnt_d   = win;
                    last_d  = win;
                    sa_d    = win ? a1 : a0;
                    sb_d    = (win ? b1 : b0) ^ {WIDTH{win_sub}};
                    carry_d = win_sub;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                sa_d    = sa_q >> 1;
                sb_d    = sb_q >> 1;
                rs_d    = {fa_sum, rs_q[WIDTH-1:1]};
                carry_d = fa_co;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    cmsb_d  = carry_q;
                    state_d = DONE;
                end
            end
            DONE: begin
                result_d = rs_q;
                cout_d   = carry_q;
                ovf_d    = cmsb_q ^ carry_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            gnt_q    <= 1'b0;
            last_q   <= 1'b1;
            sa_q     <= '0;
            sb_q     <= '0;
            rs_q     <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            cmsb_q   <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            last_q   <= last_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            rs_q     <= rs_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            cmsb_q   <= cmsb_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            cnt_q    <= cnt_d;
        end
    end

    assign busy   = (state_q != IDLE);
    assign gnt    = gnt_q;
    assign done0  = (state_q == DONE) && !gnt_q;
    assign done1  = (state_q == DONE) && gnt_q;
    assign result = result_q;
    assign cout   = cout_q;
    assign ovf    = ovf_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl (WIDTH=8): directed vector table, randomized ops
// against an arithmetic reference model, and multi-cycle corner sequences.
module tb_serial_adder_ctrl;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req0 = 1'b0, req1 = 1'b0;
    logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic         sub0 = 1'b0, sub1 = 1'b0;
    logic         busy, gnt, done0, done1, cout, ovf;
    logic [W-1:0] result;

    int checks = 0;
    int errors = 0;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .a0(a0), .b0(b0), .sub0(sub0),
        .req1(req1), .a1(a1), .b1(b1), .sub1(sub1),
        .busy(busy), .gnt(gnt), .done0(done0), .done1(done1),
        .result(result), .cout(cout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           who;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
        logic [W-1:0] res;
        logic         co;
        logic         ov;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic, unsigned for carry, signed for overflow.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        int ua, ub, sa, sb, sr;
        logic [W-1:0] r;
        logic co, ov;
        ua = a; ub = b;
        sa = $signed(a); sb = $signed(b);
        r  = s ? (a - b) : (a + b);
        co = s ? (ua >= ub) : ((ua + ub) > 255);
        sr = s ? (sa - sb) : (sa + sb);
        ov = (sr > 127) || (sr < -128);
        return {ov, co, r};
    endfunction

    // Done pulses must be exclusive and at least WIDTH+2 cycles apart.
    int cyc = 0;
    int last_done = -100;
    always @(negedge clk) begin
        cyc++;
        if (done0 || done1) begin
            checks++;
            if ((done0 && done1) || (cyc - last_done < W + 2)) begin
                errors++;
                $display("FAIL done_pulse: cycle %0d done0=%b done1=%b gap=%0d, need exclusive and gap>=%0d",
                         cyc, done0, done1, cyc - last_done, W + 2);
            end
            last_done = cyc;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Single-requester op: checks latency, busy length, done line and outputs.
    task automatic run_op(input int who, input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          input logic [W-1:0] er, input logic ec, input logic eo, input string tag);
        int busy_n;
        int done_k;
        @(negedge clk);
        if (who == 0) begin req0 = 1'b1; a0 = a; b0 = b; sub0 = s; end
        else          begin req1 = 1'b1; a1 = a; b1 = b; sub1 = s; end
        busy_n = 0;
        done_k = -1;
        for (int k = 1; k <= 20 && done_k < 0; k++) begin
            @(negedge clk);
            if (k == 1) begin req0 = 1'b0; req1 = 1'b0; end
            if (busy) busy_n++;
            if (done0 || done1) begin
                done_k = k;
                check({tag, " done_line"}, {30'd0, done1, done0}, (who == 0) ? 32'd1 : 32'd2);
            end
        end
        check({tag, " done_latency"}, done_k, W + 1);
        check({tag, " busy_cycles"}, busy_n, W + 1);
        @(negedge clk);
        check({tag, " result"}, result, er);
        check({tag, " cout"}, cout, ec);
        check({tag, " ovf"}, ovf, eo);
        check({tag, " gnt"}, gnt, who);
        check({tag, " busy_after"}, busy, 0);
    endtask

    task automatic wait_done(output int who);
        who = -1;
        for (int k = 0; k < 20 && who < 0; k++) begin
            @(negedge clk);
            if (done0 || done1) who = done1 ? 1 : 0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W+1:0] m;
        int who;
        int seen;
        logic [W-1:0] ra, rb;
        logic rs;
        int rw;

        vecs[0] = '{0, 8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 1'b0};
        vecs[1] = '{1, 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0};
        vecs[2] = '{1, 8'h07, 8'h05, 1'b1, 8'h02, 1'b1, 1'b0};
        vecs[3] = '{0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[4] = '{0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[5] = '{1, 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};

        do_reset();
        check("rst busy", busy, 0);
        check("rst gnt", gnt, 0);
        check("rst done", {done1, done0}, 0);
        check("rst result", result, 0);
        check("rst cout", cout, 0);
        check("rst ovf", ovf, 0);

        foreach (vecs[i])
            run_op(vecs[i].who, vecs[i].a, vecs[i].b, vecs[i].s,
                   vecs[i].res, vecs[i].co, vecs[i].ov, $sformatf("vec%0d", i));

        for (int i = 0; i < 40; i++) begin
            rw = $urandom_range(0, 1);
            ra = W'($urandom);
            rb = W'($urandom);
            rs = 1'($urandom);
            m  = model(ra, rb, rs);
            run_op(rw, ra, rb, rs, m[W-1:0], m[W], m[W+1], $sformatf("rnd%0d", i));
        end

        // Both requests held from reset: strict alternation starting with 0.
        do_reset();
        @(negedge clk);
        a0 = 8'h21; b0 = 8'h13; sub0 = 1'b0;
        a1 = 8'h40; b1 = 8'h55; sub1 = 1'b1;
        req0 = 1'b1; req1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_done(who);
            check($sformatf("alt%0d order", i), who, i % 2);
            check($sformatf("alt%0d gnt", i), gnt, i % 2);
            if (i == 3) begin req0 = 1'b0; req1 = 1'b0; end
            m = (i % 2 == 0) ? model(8'h21, 8'h13, 1'b0) : model(8'h40, 8'h55, 1'b1);
            @(negedge clk);
            check($sformatf("alt%0d result", i), result, m[W-1:0]);
            check($sformatf("alt%0d cout", i), cout, m[W]);
            check($sformatf("alt%0d ovf", i), ovf, m[W+1]);
        end

        // Reset during the 4th SHIFT cycle aborts the op with no done pulse.
        @(negedge clk);
        req0 = 1'b1; a0 = 8'h55; b0 = 8'h0A; sub0 = 1'b0;
        seen = 0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 1) req0 = 1'b0;
            if (done0 || done1) seen++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort busy", busy, 0);
        check("abort result", result, 0);
        check("abort cout", cout, 0);
        check("abort ovf", ovf, 0);
        check("abort gnt", gnt, 0);
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (done0 || done1) seen++;
        end
        check("abort no_done", seen, 0);
        m = model(8'h55, 8'h0A, 1'b0);
        run_op(0, 8'h55, 8'h0A, 1'b0, m[W-1:0], m[W], m[W+1], "post_abort");

        // Operand changes after grant are ignored; a short req1 pulse is not queued.
        @(negedge clk);
        req0 = 1'b1; a0 = 8'h10; b0 = 8'h01; sub0 = 1'b0;
        who = -1;
        seen = 0;
        for (int k = 1; k <= 20 && who < 0; k++) begin
            @(negedge clk);
            if (k == 1) begin req0 = 1'b0; a0 = 8'hFF; b0 = 8'h77; sub0 = 1'b1; end
            if (k == 3) begin req1 = 1'b1; a1 = 8'h33; b1 = 8'h44; end
            if (k == 5) req1 = 1'b0;
            if (done0 || done1) begin
                who = done1 ? 1 : 0;
                check("latch done_k", k, W + 1);
            end
        end
        check("latch who", who, 0);
        @(negedge clk);
        check("latch result", result, 8'h11);
        check("latch cout", cout, 0);
        check("latch ovf", ovf, 0);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done1) seen++;
        end
        check("latch no_done1", seen, 0);
        check("latch idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
